pdm_mic_capture: RTL

//  Parametrised PDM microphone front end: generates the mic clock, samples 1-bit PDM

---
 rtl/pdm_mic_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture
//   PDM microphone front end. Generates the mic clock, samples 1-bit PDM data
//   for one (left) or two (left + right) channels on opposite mclk edges,
//   decimates by counting ones over DECIM bits per channel, and presents the
//   PCM result on a valid/ready port. Optional PWM monitor drives an amplifier.
//
//   Build option: define MIC_PWM_LOOP_EN to build the PWM monitor on ampPWM;
//   without it ampPWM is tied low.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   en         capture enable; low forces IDLE
//   mclk       PDM mic clock, clk/(2*CLK_DIV)
//   micLRSel   constant LR_SEL
//   micData    PDM data, asynchronous to clk
//   pcm_data   [SAMPLE_W-1:0] left, next SAMPLE_W bits right (stereo)
//   pcm_valid  sample available
//   pcm_ready  consumer accepts sample
//   overflow   sticky: a sample was overwritten before being accepted
//   ampPWM     PWM of the last left sample (MIC_PWM_LOOP_EN) or 0
//   ampSD      amplifier enable, high only while running
module pdm_mic_capture #(
    parameter int CLK_DIV  = 25,
    parameter int DECIM    = 64,
    parameter int SAMPLE_W = 8,
    parameter int CHANNELS = 1,
    parameter int WARMUP   = 4,
    parameter bit LR_SEL   = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    output logic                         mclk,
    output logic                         micLRSel,
    input  logic                         micData,
    output logic [CHANNELS*SAMPLE_W-1:0] pcm_data,
    output logic                         pcm_valid,
    input  logic                         pcm_ready,
    output logic                         overflow,
    output logic                         ampPWM,
    output logic                         ampSD
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DECIM + 1);
    localparam int WRM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int MAXV  = (1 << SAMPLE_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [1:0]                         sync_q, sync_d;
    logic [DIV_W-1:0]                   div_q, div_d;
    logic                               mclk_q, mclk_d;
    logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]                   ones_l_q, ones_l_d;
    logic [CNT_W-1:0]                   ones_r_q, ones_r_d;
    logic [WRM_W-1:0]                   warm_q, warm_d;
    logic [CHANNELS-1:0][SAMPLE_W-1:0]  pcm_q, pcm_d;
    logic                               valid_q, valid_d;
    logic                               ovf_q, ovf_d;

    logic                               bit_in;
    logic                               left_smp, right_smp, frame_end;
    logic [CNT_W-1:0]                   l_sum, r_sum;

    function automatic logic [SAMPLE_W-1:0] sat(input logic [CNT_W-1:0] v);
        if (32'(v) > MAXV) sat = SAMPLE_W'(MAXV);
        else               sat = SAMPLE_W'(v);
    endfunction

    assign bit_in = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], micData};
        state_d   = state_q;
        div_d     = div_q;
        mclk_d    = mclk_q;
        bit_cnt_d = bit_cnt_q;
        ones_l_d  = ones_l_q;
        ones_r_d  = ones_r_q;
        warm_d    = warm_q;
        pcm_d     = pcm_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        left_smp  = 1'b0;
        right_smp = 1'b0;
        frame_end = 1'b0;
        l_sum     = ones_l_q;
        r_sum     = ones_r_q;

        if (valid_q && pcm_ready) valid_d = 1'b0;

        if (!en) begin
            state_d   = S_IDLE;
            div_d     = '0;
            mclk_d    = 1'b0;
            bit_cnt_d = '0;
            ones_l_d  = '0;
            ones_r_d  = '0;
            warm_d    = '0;
            valid_d   = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = (WARMUP == 0) ? S_RUN : S_WARM;
        end else begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d     = '0;
                mclk_d    = !mclk_q;
                left_smp  = mclk_q;                        // end of high phase
                right_smp = !mclk_q && (CHANNELS == 2);    // end of low phase
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (left_smp) begin
                l_sum     = ones_l_q + CNT_W'(bit_in);
                ones_l_d  = l_sum;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                frame_end = (CHANNELS == 1) && (bit_cnt_q == CNT_W'(DECIM - 1));
            end

            // In stereo bit_cnt already counts the paired left bit, so it runs
            // 1..DECIM here; a right slot before any left bit (first low phase
            // after enable) has nothing to pair with and is skipped.
            if (right_smp && bit_cnt_q != '0) begin
                r_sum     = ones_r_q + CNT_W'(bit_in);
                ones_r_d  = r_sum;
                frame_end = (bit_cnt_q == CNT_W'(DECIM));
            end

            // The closing bit is already folded into l_sum/r_sum.
            if (frame_end) begin
                bit_cnt_d = '0;
                ones_l_d  = '0;
                ones_r_d  = '0;
                if (state_q == S_WARM) begin
                    if (warm_q == WRM_W'(WARMUP - 1)) begin
                        state_d = S_RUN;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + WRM_W'(1);
                    end
                end else begin
                    pcm_d[0] = sat(l_sum);
                    if (CHANNELS == 2) pcm_d[CHANNELS-1] = sat(r_sum);
                    if (valid_q && !pcm_ready) ovf_d = 1'b1;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            div_q     <= '0;
            mclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            ones_l_q  <= '0;
            ones_r_q  <= '0;
            warm_q    <= '0;
            pcm_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            div_q     <= div_d;
            mclk_q    <= mclk_d;
            bit_cnt_q <= bit_cnt_d;
            ones_l_q  <= ones_l_d;
            ones_r_q  <= ones_r_d;
            warm_q    <= warm_d;
            pcm_q     <= pcm_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef MIC_PWM_LOOP_EN
    // Period is MAXV counts so duty MAXV gives a constant high output.
    logic [SAMPLE_W-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = '0;
        if (state_q == S_RUN && pwm_q != SAMPLE_W'(MAXV - 1)) pwm_d = pwm_q + SAMPLE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) pwm_q <= '0;
        else       pwm_q <= pwm_d;
    end

    assign ampPWM = (state_q == S_RUN) && (pwm_q < pcm_q[0]);
`else
    assign ampPWM = 1'b0;
`endif

    assign mclk      = mclk_q;
    assign micLRSel  = LR_SEL;
    assign pcm_data  = pcm_q;
    assign pcm_valid = valid_q;
    assign overflow  = ovf_q;
    assign ampSD     = (state_q == S_RUN);

endmodule
